// File: rtl/br_pkg.sv
// Shared branch-predictor widths and the branch order buffer entry layout.
// The predictor and the BOB both import this, so their field widths always agree.
package br_pkg;

    localparam int GHIST_W = 12;
    localparam int LHIST_W = 10;
    localparam int PC_W    = 64;

    typedef struct packed {
        logic [PC_W-1:0]    brpc;
        logic [GHIST_W-1:0] bhr;
        logic [LHIST_W-1:0] bht;
        logic               chwe;
        logic               chbrdir;
        logic               pred;
    } bob_entry_t;

endpackage

// File: rtl/circ_ptr.sv
// Circular pointer: +1 per inc with natural wrap at 2**PTR_W, synchronous clear.
// Clear wins over increment; async active-high reset to zero.
module circ_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + PTR_W'(1);
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/br_order_buf.sv
// In-order circular buffer of per-branch predictor metadata; head read is combinational
// (zero latency), write-to-head latency 1. Enqueue is dropped when full (fetch must stall on bob_full_o).
module br_order_buf
    import br_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enq_vld_i,
    input  logic [PC_W-1:0]    enq_brpc_i,
    input  logic [GHIST_W-1:0] enq_bhr_i,
    input  logic [LHIST_W-1:0] enq_bht_i,
    input  logic               enq_chwe_i,
    input  logic               enq_chbrdir_i,
    input  logic               enq_pred_i,
    input  logic               deq_i,
    input  logic               rt_brdir_i,
    input  logic               flush_i,
    output logic               bob_valid_o,
    output logic [PC_W-1:0]    bob_brpc_o,
    output logic [GHIST_W-1:0] bob_bhr_o,
    output logic [LHIST_W-1:0] bob_bht_o,
    output logic               bob_chwe_o,
    output logic               bob_chbrdir_o,
    output logic               bob_mispred_o,
    output logic               bob_full_o,
    output logic [PTR_W:0]     bob_count_o,
    output logic               bob_err_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    bob_entry_t       mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W:0]   count_q;
    logic             err_q;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;

    logic       full;
    logic       head_vld;
    logic       enq_ok;
    logic       deq_ok;
    logic       err_set;
    bob_entry_t head_ent;
    bob_entry_t wr_ent;

    assign full     = (count_q == DEPTH_C);
    assign head_vld = valid_q[head_q];

    // Flush discards the enqueue silently; a full-buffer enqueue is an error even if a deq frees a slot this cycle.
    assign enq_ok  = enq_vld_i & ~full & ~flush_i;
    assign deq_ok  = deq_i & head_vld;
    assign err_set = (enq_vld_i & full & ~flush_i) | (deq_i & ~head_vld);

    circ_ptr #(.PTR_W(PTR_W)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .clr   (flush_i),
        .inc   (deq_ok),
        .ptr   (head_q)
    );

    circ_ptr #(.PTR_W(PTR_W)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .clr   (flush_i),
        .inc   (enq_ok),
        .ptr   (tail_q)
    );

    always_comb begin
        wr_ent         = '0;
        wr_ent.brpc    = enq_brpc_i;
        wr_ent.bhr     = enq_bhr_i;
        wr_ent.bht     = enq_bht_i;
        wr_ent.chwe    = enq_chwe_i;
        wr_ent.chbrdir = enq_chbrdir_i;
        wr_ent.pred    = enq_pred_i;
    end

    // Payload needs no reset: every read is gated by the entry's valid bit.
    always_ff @(posedge clock) begin
        if (enq_ok) begin
            mem[tail_q] <= wr_ent;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (flush_i) begin
                valid_q <= '0;
                count_q <= '0;
            end else begin
                if (enq_ok) begin
                    valid_q[tail_q] <= 1'b1;
                end
                if (deq_ok) begin
                    valid_q[head_q] <= 1'b0;
                end
                case ({enq_ok, deq_ok})
                    2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                    2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_comb begin
        head_ent = '0;
        if (head_vld) begin
            head_ent = mem[head_q];
        end
    end

    assign bob_valid_o   = head_vld;
    assign bob_brpc_o    = head_ent.brpc;
    assign bob_bhr_o     = head_ent.bhr;
    assign bob_bht_o     = head_ent.bht;
    assign bob_chwe_o    = head_ent.chwe;
    assign bob_chbrdir_o = head_ent.chbrdir;
    assign bob_mispred_o = deq_i & head_vld & (rt_brdir_i != head_ent.pred);
    assign bob_full_o    = full;
    assign bob_count_o   = count_q;
    assign bob_err_o     = err_q;

endmodule

// File: doc/br_order_buf.md
Name: br_order_buf

Overview:
Branch order buffer (BOB): in-order circular FIFO holding per-branch prediction metadata captured at fetch stage F1 (PC, global history, local history, choice-update info, predicted direction). At retire it presents the oldest entry to the tournament predictor for its non-speculative PHT/BHT/choice update and for global-history repair on flush. It is the consumer end of the predictor's bhr/bht/chwe/chbrdir outputs and the producer of its bob_* inputs.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2.
PTR_W, 4, log2(DEPTH).

Ports:
clock  in  1  single clock; all state on the rising edge.
reset  in  1  asynchronous, active-high reset.
enq_vld_i  in  1  F1 branch fetched: (br_cond | br_uncond) & fill_f1.
enq_brpc_i  in  64  branch PC.
enq_bhr_i  in  12  global history at prediction (bpd_bhr).
enq_bht_i  in  10  local history at prediction (bpd_bht).
enq_chwe_i  in  1  choice-PHT write enable candidate (bpd_chwe).
enq_chbrdir_i  in  1  local prediction used for the choice update (bpd_chbrdir).
enq_pred_i  in  1  final predicted direction.
deq_i  in  1  retire of oldest branch (brcond_vld_rt | brindir_vld_rt).
rt_brdir_i  in  1  resolved direction at retire.
flush_i  in  1  retire-stage pipeline flush.
bob_valid_o  out  1  head entry valid.
bob_brpc_o  out  64  head PC.
bob_bhr_o  out  12  head global history.
bob_bht_o  out  10  head local history.
bob_chwe_o  out  1  head choice write enable.
bob_chbrdir_o  out  1  head choice direction term.
bob_mispred_o  out  1  deq_i & bob_valid_o & (rt_brdir_i != head pred).
bob_full_o  out  1  count == DEPTH; stalls fetch.
bob_count_o  out  PTR_W+1  occupancy.
bob_err_o  out  1  sticky: enqueue while full, or dequeue while empty.

Behaviour:
- Storage: DEPTH-entry array plus per-entry valid bit; head, tail (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (asynchronous, any cycle, including mid-operation): head=tail=0, count=0, all valid bits=0, bob_err_o=0. All outputs are then 0 (bob_full_o=0, bob_valid_o=0).
- Head outputs are combinational from the head entry, zero-gated when the head is invalid. Zero-cycle read latency: retire sees the head in the same cycle it asserts deq_i.
- Enqueue: enq_vld_i & ~bob_full_o & ~flush_i writes the entry at tail, sets its valid bit, and advances tail by 1. Data is visible at the head the next cycle at the earliest (write-to-read latency 1).
- Enqueue while full is dropped, even if deq_i is asserted in the same cycle. It sets bob_err_o.
- Dequeue: deq_i & bob_valid_o clears the head valid bit and advances head by 1. deq_i while empty is ignored and sets bob_err_o.
- Simultaneous enqueue and dequeue (not full, not empty): count is unchanged and both pointers advance.
- bob_mispred_o is combinational and valid only in the cycle deq_i is asserted.
- Flush:
  - In the flush cycle the head outputs still show the pre-flush head, so the predictor can restore bhr from bob_bhr_o when bob_valid_o=1.
  - On the following edge: head=tail=0, count=0, all valid bits cleared.
  - Flush dominates enqueue; the enqueue is dropped with no error.
  - Flush together with deq_i is legal and the result is empty.
- bob_err_o clears only on reset.
- Pointer wrap: tail advancing from DEPTH-1 goes to 0. Full/empty are decided by count, never by pointer compare.

Decomposition:
- Shared package br_pkg: GHIST_W=12, LHIST_W=10, PC_W=64, and the bob entry struct/field layout {brpc, bhr, bht, chwe, chbrdir, pred} so the predictor and BOB agree on widths.
- No sub-module is required. Optionally, a generic circ_ptr counter (increment with wrap, synchronous clear) instantiated for head and tail.

Test Plan:
- Reset then idle: all outputs 0, count 0. Assert reset mid-stream with 5 entries held: outputs return to 0 asynchronously and count=0 after release.
- Enqueue PC 0x1000, bhr 0xABC, bht 0x155, chwe=1, chbrdir=0, pred=1. The next cycle shows bob_valid_o=1 with the same values. deq_i with rt_brdir_i=0 gives bob_mispred_o=1, and bob_valid_o=0 the cycle after.
- Enqueue 16 distinct PCs: bob_full_o=1 and count=16. A 17th enqueue together with deq_i is dropped and bob_err_o=1. Dequeue all 16: PCs come out in order, and tail/head wrap from 15 to 0.
- 20 cycles of enqueue and dequeue every cycle at count 3: count stays 3, no error, and FIFO order is preserved across the wrap.
- With 4 entries held (head bhr 0x123), assert flush_i with enq_vld_i: in that cycle bob_valid_o=1 and bob_bhr_o=0x123. The next cycle count=0, bob_valid_o=0, and the enqueue was not stored.
- deq_i on an empty buffer: nothing changes except bob_err_o=1, which stays 1 until reset.
